// File: rtl/wb_stage.sv
// wb_stage: register-file write-back arbiter for ALU results and LSU loads.
// Loads are tracked by a small FSM (IDLE/BEAT1/BEAT2). Returned data is
// aligned, width-extracted and sign/zero-extended before it is written.
// An ALU result that collides with a load write waits in a one-entry skid.
//
// Build option: define WB_MISALIGN_EN to merge misaligned loads from two
// data beats. Without it, a misaligned load raises load_misalign_err for one
// cycle and writes nothing.
module wb_stage #(
    parameter int RF_ADDR_W = 5,
    parameter int RST_HOLD  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 alu_wb_valid,
    input  logic [RF_ADDR_W-1:0] alu_wb_addr,
    input  logic [31:0]          alu_wb_data,
    input  logic                 load_valid,
    input  logic [2:0]           load_type,
    input  logic [1:0]           load_offset,
    input  logic [RF_ADDR_W-1:0] load_rd,
    input  logic                 data_rvalid,
    input  logic [31:0]          data_rdata,
    output logic                 rf_we,
    output logic [RF_ADDR_W-1:0] rf_waddr,
    output logic [31:0]          rf_wdata,
    output logic                 wb_busy,
    output logic                 load_misalign_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BEAT1 = 2'd1;
    localparam logic [1:0] S_BEAT2 = 2'd2;

    localparam int HOLD_W = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

    // Load crosses a word boundary: half at offset 3, word (or reserved) off 1..3.
    function automatic logic is_misaligned(input logic [2:0] ty, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (ty[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = (off == 2'd3);
            default: mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

    // Cut the loaded value to its width, then sign- or zero-extend to 32 bits.
    function automatic logic [31:0] extend_load(input logic [2:0] ty, input logic [31:0] raw);
        logic        sx;
        logic [31:0] res;
        sx  = 1'b0;
        res = raw;
        case (ty[1:0])
            2'b00: begin
                sx  = ~ty[2] & raw[7];
                res = {{24{sx}}, raw[7:0]};
            end
            2'b01: begin
                sx  = ~ty[2] & raw[15];
                res = {{16{sx}}, raw[15:0]};
            end
            default: res = raw;
        endcase
        return res;
    endfunction

    // Control state (asynchronously reset).
    logic [1:0]           state_q, state_d;
    logic                 skid_vld_q, skid_vld_d;
    logic                 rf_we_q, rf_we_d;
    logic [RF_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [31:0]          rf_wdata_q, rf_wdata_d;
    logic                 err_q, err_d;
    logic                 hold_q;
    logic [HOLD_W-1:0]    hold_cnt_q;

    // Data-path holding registers (no reset needed; qualified by control).
    logic [2:0]           ld_type_q;
    logic [1:0]           ld_off_q;
    logic [RF_ADDR_W-1:0] ld_rd_q;
    logic [RF_ADDR_W-1:0] skid_addr_q;
    logic [31:0]          skid_data_q;
`ifdef WB_MISALIGN_EN
    logic [31:0]          beat1_q;
`endif

    // Combinational helpers.
    logic                 ld_accept;
    logic                 ld_mis;
    logic                 ld_final;
    logic                 ld_err;
    logic [63:0]          ld_data64;
    logic [31:0]          ld_shifted;
    logic [31:0]          ld_result;
    logic                 skid_load;
    logic                 wr_vld;
    logic [RF_ADDR_W-1:0] wr_addr;
    logic [31:0]          wr_data;

    assign ld_accept = (state_q == S_IDLE) && load_valid;
    assign ld_mis    = is_misaligned(ld_type_q, ld_off_q);

`ifdef WB_MISALIGN_EN
    assign ld_final  = data_rvalid &&
                       (((state_q == S_BEAT1) && !ld_mis) || (state_q == S_BEAT2));
    assign ld_err    = 1'b0;
    // Second beat supplies the upper bytes; shifting the 64-bit pair by the
    // byte offset lines the requested bytes up at bit 0.
    assign ld_data64 = (state_q == S_BEAT2) ? {data_rdata, beat1_q} : {32'd0, data_rdata};
`else
    assign ld_final  = data_rvalid && (state_q == S_BEAT1) && !ld_mis;
    assign ld_err    = data_rvalid && (state_q == S_BEAT1) && ld_mis;
    assign ld_data64 = {32'd0, data_rdata};
`endif

    assign ld_shifted = 32'(ld_data64 >> {ld_off_q, 3'b000});
    assign ld_result  = extend_load(ld_type_q, ld_shifted);

    // Load FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_valid) state_d = S_BEAT1;
            end
            S_BEAT1: begin
`ifdef WB_MISALIGN_EN
                if (data_rvalid) state_d = ld_mis ? S_BEAT2 : S_IDLE;
`else
                if (data_rvalid) state_d = S_IDLE;
`endif
            end
`ifdef WB_MISALIGN_EN
            S_BEAT2: begin
                if (data_rvalid) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Write arbitration: load beats skid, skid beats a fresh ALU result.
    always_comb begin
        skid_vld_d = skid_vld_q;
        skid_load  = 1'b0;
        wr_vld     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        err_d      = ld_err;

        if (ld_final) begin
            wr_vld  = 1'b1;
            wr_addr = ld_rd_q;
            wr_data = ld_result;
            // A colliding ALU result parks in the skid; dropped if already full.
            if (alu_wb_valid && !skid_vld_q) begin
                skid_vld_d = 1'b1;
                skid_load  = 1'b1;
            end
        end else if (skid_vld_q) begin
            // ALU input arriving while the skid drains is dropped.
            wr_vld     = 1'b1;
            wr_addr    = skid_addr_q;
            wr_data    = skid_data_q;
            skid_vld_d = 1'b0;
        end else if (alu_wb_valid) begin
            wr_vld  = 1'b1;
            wr_addr = alu_wb_addr;
            wr_data = alu_wb_data;
        end

        // x0 is hard-wired: suppress the write but keep outputs at last value.
        if (wr_vld && (wr_addr != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = wr_addr;
            rf_wdata_d = wr_data;
        end
    end

    // Control registers and write-port outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            skid_vld_q <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            skid_vld_q <= skid_vld_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
        end
    end

    // Post-reset busy hold: cleared after RST_HOLD extra cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q     <= 1'b1;
            hold_cnt_q <= HOLD_W'(RST_HOLD);
        end else if (hold_q) begin
            if (hold_cnt_q == '0) begin
                hold_q <= 1'b0;
            end else begin
                hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
            end
        end
    end

    // Capture load attributes, first beat and skid payload.
    always_ff @(posedge clk) begin
        if (ld_accept) begin
            ld_type_q <= load_type;
            ld_off_q  <= load_offset;
            ld_rd_q   <= load_rd;
        end
        if (skid_load) begin
            skid_addr_q <= alu_wb_addr;
            skid_data_q <= alu_wb_data;
        end
`ifdef WB_MISALIGN_EN
        if ((state_q == S_BEAT1) && data_rvalid) begin
            beat1_q <= data_rdata;
        end
`endif
    end

    assign rf_we             = rf_we_q;
    assign rf_waddr          = rf_waddr_q;
    assign rf_wdata          = rf_wdata_q;
    assign load_misalign_err = err_q;
    assign wb_busy           = (state_q != S_IDLE) | skid_vld_q | hold_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter RF_ADDR_W, default 5, register-file address width (rd fields).
REQ-002 Parameter RST_HOLD, default 0, extra cycles wb_busy stays high after reset release.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 alu_wb_valid  in  1  non-load result from mem stage valid this cycle.
REQ-006 alu_wb_addr  in  RF_ADDR_W  destination register of non-load result.
REQ-007 alu_wb_data  in  32  non-load result data.
REQ-008 load_valid  in  1  load request granted on LSU this cycle (data_req & data_gnt).
REQ-009 load_type  in  3  [1:0] width (00 byte, 01 half, 10 word, 11 reserved), [2] unsigned.
REQ-010 load_offset  in  2  byte offset addr[1:0] of the load.
REQ-011 load_rd  in  RF_ADDR_W  load destination register.
REQ-012 data_rvalid  in  1  LSU read data valid.
REQ-013 data_rdata  in  32  LSU read data.
REQ-014 rf_we  out  1  register-file write enable.
REQ-015 rf_waddr  out  RF_ADDR_W  register-file write address.
REQ-016 rf_wdata  out  32  register-file write data.
REQ-017 wb_busy  out  1  stall to mem stage; new loads/ALU results not accepted.
REQ-018 load_misalign_err  out  1  one-cycle pulse, misaligned load rejected.

Function
REQ-019 FSM states IDLE, BEAT1, BEAT2; load_valid accepted only in IDLE, capturing type, offset, rd.
REQ-020 IDLE->BEAT1 on accepted load_valid; BEAT1->IDLE on data_rvalid if load aligned; BEAT1->BEAT2 on data_rvalid if misaligned (half @ offset 3, word @ offset 1..3).
REQ-021 BEAT2->IDLE on data_rvalid; data_rvalid in IDLE ignored, no write.
REQ-022 Aligned extract: byte = rdata[8*off+7:8*off]; half = rdata[8*off+15:8*off]; word = rdata.
REQ-023 Misaligned: low part = beat1 rdata[31:8*off], high part = beat2 rdata low bytes, concatenated to width.
REQ-024 Byte/half zero-extended when type[2]=1, else sign-extended to 32 bits; reserved width treated as word.
REQ-025 Load write: rf_we high exactly the cycle after the final data_rvalid, rf_waddr = captured rd.
REQ-026 ALU write: rf_we high the cycle after alu_wb_valid, latency 1, if no load write that cycle.
REQ-027 Collision: load write has priority; ALU result held in one-entry skid register and written next free cycle.
REQ-028 wb_busy = (state != IDLE) | skid occupied | reset-hold active.
REQ-029 Writes with destination 0 suppressed: rf_we stays 0, FSM/skid still advance.
REQ-030 rf_waddr/rf_wdata hold last written values when rf_we=0.
REQ-031 alu_wb_valid while skid full is a protocol violation; input dropped, no other effect.

Reset
REQ-032 On reset: state IDLE, skid empty, rf_we=0, rf_waddr=0, rf_wdata=0, load_misalign_err=0, wb_busy=1.
REQ-033 Reset mid-load drops pending load and skid content; no write after release.
REQ-034 wb_busy deasserts RST_HOLD cycles after reset falls (first cycle if 0).

Configuration
REQ-035 Macro WB_MISALIGN_EN defined: misaligned loads handled by two-beat merge per REQ-020/023.
REQ-036 WB_MISALIGN_EN undefined: BEAT2 absent; misaligned load pulses load_misalign_err the cycle after its data_rvalid, no write, FSM to IDLE.

Verification
REQ-037 lb, offset 2, rdata 0x0080_0000, rd 5 -> next cycle rf_we=1, waddr 5, wdata 0xFFFF_FF80.
REQ-038 lhu, offset 0, rdata 0x1234_F00D, rd 7 -> wdata 0x0000_F00D; lh same -> 0xFFFF_F00D.
REQ-039 lw offset 3, beat1 0xAA00_0000, beat2 0x00CC_BBDD, rd 9 -> wdata 0xCCBB_DDAA (macro on); macro off -> err pulse, no write.
REQ-040 ALU result (rd 3, 0x55) same cycle as final load data (rd 4) -> rd 4 written first, rd 3 next cycle, wb_busy high in between.
REQ-041 alu_wb_valid to rd 0 -> rf_we stays 0; reset in BEAT1 -> later data_rvalid produces no write.
